lcd_refresh_scheduler: RTL and testbench
========================================

# lcd_refresh_scheduler

Sequencer and arbiter in front of `LCD_Controller` for the 16x2 character LCD. Runs the power-on command sequence, then keeps the panel in sync with a 32-byte character buffer that any logic (ADC readout, status, sensor values) writes at full clock rate. Display refresh passes and externally requested LCD commands share the one controller transaction port. The controller sees a single well-formed start/done stream with an inter-transaction delay.

## Interface
- `DLY_CYCLES`, default 262143: idle cycles between consecutive LCD transactions. Minimum 1.
- `DLY_W`, default 18: width of the delay counter. Must satisfy 2^DLY_W > DLY_CYCLES.
- `iCLK` in 1: system clock.
- `iRST_N` in 1: asynchronous, active-low reset.
- `iWR_EN` in 1: buffer write strobe, accepted every cycle.
- `iWR_ADDR` in 5: buffer address. 0-15 = line 1, 16-31 = line 2.
- `iWR_CHAR` in 8: character code.
- `iCMD_REQ` in 1: level request for a raw LCD command (RS=0).
- `iCMD` in 8: command byte. Held stable while `iCMD_REQ`=1.
- `oCMD_ACK` out 1: one-cycle pulse when the requested command has completed.
- `oLCD_DATA` out 8: to `LCD_Controller.iDATA`.
- `oLCD_RS` out 1: to `LCD_Controller.iRS`.
- `oLCD_START` out 1: to `LCD_Controller.iStart`.
- `iLCD_DONE` in 1: from `LCD_Controller.oDone`.
- `oBUSY` out 1: 1 whenever state ≠ IDLE.
- `oINIT_DONE` out 1: sticky. Set when the init sequence has completed.

## Operation
- Buffer: 32 x 8, every entry resets to 0x20. `dirty` flag resets to 1.
- States: LOAD, WAIT_DONE, DELAY, NEXT, IDLE. The mode register takes the values INIT, REFRESH or CMD.
- Mode INIT issues 5 commands in order: 0x38, 0x0C, 0x01, 0x06, 0x80.
- Mode REFRESH issues 34 transactions, indexed 0-33:
  - index 0: cmd 0x80
  - index 1-16: data buf[0..15]
  - index 17: cmd 0xC0
  - index 18-33: data buf[16..31]
  - Data transactions drive RS=1; command transactions drive RS=0.
- Mode CMD issues 1 transaction: the `iCMD` byte, RS=0.
- LOAD:
  - Register `oLCD_DATA` and `oLCD_RS` from the current sequence entry; buffer bytes are read at this cycle.
  - Set `oLCD_START`=1.
  - Go to WAIT_DONE.
- WAIT_DONE: hold outputs. On `iLCD_DONE`=1, drop `oLCD_START` and go to DELAY.
- DELAY: count 0..DLY_CYCLES-1, then go to NEXT.
- NEXT:
  - If the index is the last one of the current mode, do the completion step for that mode, then go to IDLE.
    - INIT completion: set `oINIT_DONE`.
    - CMD completion: pulse `oCMD_ACK` and set `dirty` (the command may have altered the display).
  - Otherwise increment the index and go to LOAD.
- IDLE priority, evaluated each cycle:
  1. `iCMD_REQ`=1: latch `iCMD`, mode CMD, go to LOAD.
  2. `dirty`=1: clear `dirty`, mode REFRESH, index 0, go to LOAD.
  3. Otherwise stay in IDLE.
- Commands are served only from IDLE. A pass in progress always completes before a command is served.
- Any `iWR_EN` sets `dirty`. If a write coincides with the IDLE cycle that clears `dirty`, the set wins.
- A write to an entry that has already been loaded in the current pass appears on the next pass. A write to an entry not yet loaded appears in the current pass.
- `iLCD_DONE` is ignored outside WAIT_DONE.

## Timing
- Reset values:
  - `oLCD_START`=0, `oLCD_DATA`=0x00, `oLCD_RS`=0, `oCMD_ACK`=0, `oINIT_DONE`=0.
  - `oBUSY`=1; the state resets to LOAD, mode INIT, index 0.
- Reset asserted mid-transaction:
  - All outputs return to their reset values immediately.
  - The buffer returns to all 0x20 and `dirty` returns to 1.
  - The init sequence reruns after release.
- `oLCD_START` rises 1 cycle after LOAD is entered.
- Per-transaction cost = 1 (LOAD) + N (cycles until DONE) + DLY_CYCLES + 1 (NEXT).
- `oLCD_DATA` and `oLCD_RS` are stable from the rise of `oLCD_START` through the end of DELAY.
- IDLE to LOAD takes 1 cycle. `oCMD_ACK` is high for exactly the NEXT cycle's successor (the first IDLE cycle). `iCMD_REQ` must be dropped within that cycle or the command is reissued.
- First refresh pass: begins in the first IDLE cycle after init completes, because `dirty` resets to 1.

## Configuration
- `LCD_SCHED_CMD_EN` defined: external command path present, exactly as described above.
- `LCD_SCHED_CMD_EN` undefined:
  - `iCMD_REQ` and `iCMD` are ignored and `oCMD_ACK` is tied to 0.
  - IDLE only considers `dirty`; mode CMD does not exist.

## Test plan
Bench settings for all scenarios: DLY_CYCLES=4; controller model asserts `iLCD_DONE` for 1 cycle, 3 cycles after START.
- Reset release → transactions 0x38, 0x0C, 0x01, 0x06, 0x80 (all RS=0) → `oINIT_DONE`=1 → 34-transaction pass with 32 data bytes of 0x20 → `oBUSY`=0.
- Idle scheduler; write addr 0 ← 0x48, addr 17 ← 0x21 → new pass: transaction 1 = RS=1 0x48; transaction 17 = RS=0 0xC0; transaction 19 = RS=1 0x21.
- During a pass at index 10, write addr 3 ← 0x41 and addr 12 ← 0x42:
  - the current pass shows 0x42 at index 13;
  - the following pass shows 0x41 at index 4.
- `iCMD_REQ`=1 with `iCMD`=0x01 while a pass is running:
  - no command is issued before index 33 completes;
  - then exactly one RS=0 0x01 transaction;
  - `oCMD_ACK` pulses once;
  - a full refresh pass follows.
- Assert `iRST_N`=0 while in WAIT_DONE of refresh index 20 → `oLCD_START`=0 and `oINIT_DONE`=0 in the same cycle; after release the init sequence restarts at 0x38.
- Build without `LCD_SCHED_CMD_EN`: hold `iCMD_REQ`=1 → no command transaction, `oCMD_ACK` stays 0, refresh passes remain unaffected.

Source files
------------

// File: rtl/lcd_refresh_scheduler.sv
// lcd_refresh_scheduler: runs the LCD power-on command sequence, then mirrors a 32-byte
// character buffer onto a 16x2 panel and arbitrates refresh passes against raw LCD commands.
//   iCLK, iRST_N                  clock, asynchronous active-low reset
//   iWR_EN, iWR_ADDR, iWR_CHAR    buffer write port (0-15 line 1, 16-31 line 2)
//   iCMD_REQ, iCMD, oCMD_ACK      raw command request/ack (present only with LCD_SCHED_CMD_EN)
//   oLCD_DATA, oLCD_RS            byte and register select presented to the LCD controller
//   oLCD_START, iLCD_DONE         controller transaction handshake
//   oBUSY, oINIT_DONE             sequencer status
// Define LCD_SCHED_CMD_EN to include the external command path.
module lcd_refresh_scheduler #(
  parameter int DLY_CYCLES = 262143,
  parameter int DLY_W      = 18
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iWR_EN,
  input  logic [4:0] iWR_ADDR,
  input  logic [7:0] iWR_CHAR,
  input  logic       iCMD_REQ,
  input  logic [7:0] iCMD,
  output logic       oCMD_ACK,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_START,
  input  logic       iLCD_DONE,
  output logic       oBUSY,
  output logic       oINIT_DONE
);
  typedef enum logic [2:0] {S_LOAD, S_WAIT_DONE, S_DELAY, S_NEXT, S_IDLE} state_t;
  typedef enum logic [1:0] {M_INIT, M_REFRESH, M_CMD} mode_t;
  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [5:0]       idx_q, idx_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             start_q, start_d;
  logic             ack_q, ack_d;
  logic             init_done_q, init_done_d;
  logic             dirty_q, dirty_d;
  logic [7:0]       buf_q [32];
  logic [4:0]       rd_addr;
  logic [7:0]       ent_data;
  logic             ent_rs;
  logic             last;
  logic [7:0]       cmd_q;
  logic             cmd_go;
`ifdef LCD_SCHED_CMD_EN
  assign cmd_go = iCMD_REQ;
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) cmd_q <= 8'h00;
    else if (state_q == S_IDLE && iCMD_REQ) cmd_q <= iCMD;
`else
  logic unused_cmd;
  assign cmd_go     = 1'b0;
  assign cmd_q      = 8'h00;
  assign unused_cmd = ^{iCMD_REQ, iCMD};
`endif
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    else if (iWR_EN) buf_q[iWR_ADDR] <= iWR_CHAR;
  // Refresh index 1-16 maps to buf[0..15], 18-33 to buf[16..31]; 0 and 17 are cursor commands.
  assign rd_addr = (idx_q <= 6'd16) ? 5'(idx_q - 6'd1) : 5'(idx_q - 6'd2);
  always_comb begin
    ent_data = 8'h00;
    ent_rs   = 1'b0;
    last     = 1'b0;
    case (mode_q)
      M_INIT: begin
        ent_data = idx_q == 6'd0 ? 8'h38 : idx_q == 6'd1 ? 8'h0C : idx_q == 6'd2 ? 8'h01 :
                   idx_q == 6'd3 ? 8'h06 : 8'h80;
        last     = idx_q == 6'd4;
      end
      M_REFRESH: begin
        ent_rs   = idx_q != 6'd0 && idx_q != 6'd17;
        ent_data = idx_q == 6'd0 ? 8'h80 : idx_q == 6'd17 ? 8'hC0 : buf_q[rd_addr];
        last     = idx_q == 6'd33;
      end
      default: begin
        ent_data = cmd_q;
        last     = 1'b1;
      end
    endcase
  end
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    rs_d        = rs_q;
    start_d     = start_q;
    ack_d       = 1'b0;
    init_done_d = init_done_q;
    dirty_d     = dirty_q;
    case (state_q)
      S_LOAD: begin
        data_d  = ent_data;
        rs_d    = ent_rs;
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE:
        if (iLCD_DONE) begin
          start_d = 1'b0;
          state_d = S_DELAY;
        end
      S_DELAY: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == DLY_W'(DLY_CYCLES - 1) ? S_NEXT : S_DELAY;
      end
      S_NEXT:
        if (last) begin
          state_d     = S_IDLE;
          init_done_d = init_done_q | (mode_q == M_INIT);
          ack_d       = mode_q == M_CMD;
          dirty_d     = dirty_q | (mode_q == M_CMD);
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = S_LOAD;
        end
      default:
        if (cmd_go) begin
          mode_d  = M_CMD;
          idx_d   = '0;
          state_d = S_LOAD;
        end else if (dirty_q) begin
          dirty_d = 1'b0;
          mode_d  = M_REFRESH;
          idx_d   = '0;
          state_d = S_LOAD;
        end
    endcase
    // A write landing on the cycle that clears dirty must still schedule another pass.
    if (iWR_EN) dirty_d = 1'b1;
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      state_q     <= S_LOAD;
      mode_q      <= M_INIT;
      idx_q       <= '0;
      cnt_q       <= '0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      start_q     <= 1'b0;
      ack_q       <= 1'b0;
      init_done_q <= 1'b0;
      dirty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      init_done_q <= init_done_d;
      dirty_q     <= dirty_d;
    end
  assign oLCD_DATA  = data_q;
  assign oLCD_RS    = rs_q;
  assign oLCD_START = start_q;
  assign oCMD_ACK   = ack_q;
  assign oINIT_DONE = init_done_q;
  assign oBUSY      = state_q != S_IDLE;
endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// tb_lcd_refresh_scheduler: directed scoreboard bench for lcd_refresh_scheduler.
module tb_lcd_refresh_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic       cmd_req = 1'b0;
  logic [7:0] cmd = '0;
  logic       lcd_done = 1'b0;
  logic       cmd_ack, lcd_rs, lcd_start, busy, init_done;
  logic [7:0] lcd_data;
  int         tests = 0;
  int         fails = 0;
  logic [8:0] obs [0:2047];
  int         obs_n = 0;
  int         ack_cnt = 0;
  int         unstable = 0;
  logic [8:0] exp_q [$];
  int         rd = 0;
  logic [7:0] mbuf [32];
  int         base;
  int         ack0;
  lcd_refresh_scheduler #(.DLY_CYCLES(4), .DLY_W(3)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iWR_EN(wr_en), .iWR_ADDR(wr_addr), .iWR_CHAR(wr_char),
    .iCMD_REQ(cmd_req), .iCMD(cmd), .oCMD_ACK(cmd_ack), .oLCD_DATA(lcd_data), .oLCD_RS(lcd_rs),
    .oLCD_START(lcd_start), .iLCD_DONE(lcd_done), .oBUSY(busy), .oINIT_DONE(init_done)
  );
  always #5 clk = ~clk;
  initial begin
    int age;
    age = 0;
    forever begin
      @(posedge clk); #1;
      lcd_done = 1'b0;
      if (!rst_n || !lcd_start) age = 0;
      else begin
        age++;
        if (age == 4) lcd_done = 1'b1;
      end
    end
  end
  initial begin
    logic       prev;
    logic [8:0] held;
    prev = 1'b0;
    held = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) prev = 1'b0;
      else begin
        if (lcd_start && !prev) begin
          held = {lcd_rs, lcd_data};
          if (obs_n < 2048) obs[obs_n] = held;
          obs_n++;
        end else if (lcd_start && {lcd_rs, lcd_data} !== held) unstable++;
        if (cmd_ack) ack_cnt++;
        prev = lcd_start;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d transactions seen", obs_n);
    $fatal(1, "watchdog");
  end
  function automatic logic [8:0] entry(input int i);
    return i == 0 ? {1'b0, 8'h80} : i == 17 ? {1'b0, 8'hC0} :
           i < 17 ? {1'b1, mbuf[i-1]} : {1'b1, mbuf[i-2]};
  endfunction
  task automatic push_pass(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(entry(i));
  endtask
  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h80});
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] c);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  task automatic wait_obs(input int n, input string tag);
    int k;
    k = 0;
    while (obs_n < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(obs_n >= n), 32'd1);
  endtask
  task automatic settle(input string tag);
    int k;
    logic [8:0] e;
    k = 0;
    while ((obs_n < rd + exp_q.size() || busy) && k < 8000) begin
      @(negedge clk);
      k++;
    end
    repeat (30) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      assert (rd < obs_n && obs[rd] === e) else begin
        fails++;
        $error("FAIL %s[%0d]: observed %h expected %h", tag, rd, rd < obs_n ? obs[rd] : 9'h1ff, e);
      end
      rd++;
    end
    check({tag, "_count"}, 32'(obs_n), 32'(rd));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start", 32'(lcd_start), 32'd0);
    check("rst_data", 32'(lcd_data), 32'h00);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_ack", 32'(cmd_ack), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    push_init();
    push_pass(34);
    rst_n = 1'b1;
    settle("init");
    check("init_done", 32'(init_done), 32'd1);
    mbuf[0]  = 8'h48;
    mbuf[17] = 8'h21;
    push_pass(34);
    push_pass(34);
    wr(5'd0, 8'h48);
    wr(5'd17, 8'h21);
    settle("write_pass");
    base = obs_n;
    mbuf[5]  = 8'h55;
    mbuf[12] = 8'h42;
    push_pass(34);
    wr(5'd5, 8'h55);
    wait_obs(base + 11, "reach_idx10");
    wr(5'd3, 8'h41);
    wr(5'd12, 8'h42);
    mbuf[3] = 8'h41;
    push_pass(34);
    settle("mid_pass");
    base = obs_n;
    ack0 = ack_cnt;
    mbuf[31] = 8'h7A;
    push_pass(34);
    wr(5'd31, 8'h7A);
    wait_obs(base + 6, "reach_idx5");
    cmd = 8'h01;
    cmd_req = 1'b1;
`ifdef LCD_SCHED_CMD_EN
    exp_q.push_back({1'b0, 8'h01});
    push_pass(34);
    begin
      int k;
      k = 0;
      while (!cmd_ack && k < 5000) begin
        @(negedge clk);
        k++;
      end
      check("ack_seen", 32'(cmd_ack), 32'd1);
      cmd_req = 1'b0;
    end
    settle("cmd");
    check("ack_pulses", 32'(ack_cnt - ack0), 32'd1);
`else
    settle("cmd_ignored");
    check("ack_pulses", 32'(ack_cnt - ack0), 32'd0);
    cmd_req = 1'b0;
`endif
    base = obs_n;
    mbuf[0] = 8'h30;
    push_pass(21);
    wr(5'd0, 8'h30);
    wait_obs(base + 21, "reach_idx20");
    rst_n = 1'b0;
    #1;
    check("mid_rst_start", 32'(lcd_start), 32'd0);
    check("mid_rst_init_done", 32'(init_done), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_data", 32'(lcd_data), 32'h00);
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    push_init();
    push_pass(34);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle("reinit");
    check("reinit_done", 32'(init_done), 32'd1);
    check("data_stable", 32'(unstable), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
